// File: rtl/bit_debounce.sv
// bit_debounce: debounce + edge detect for an already-synchronized level.
// Ports: clk, rst_n (sync, active-low), in -> out, rise, fall, busy;
//   with DEBOUNCE_GLITCH_CNT_EN: glitch_clr in, glitch_cnt[GLITCH_W] out.
module bit_debounce #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter logic        RESET_VAL     = 1'b0,
  parameter int unsigned GLITCH_W      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in,
  output logic                out,
  output logic                rise,
  output logic                fall,
  output logic                busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  input  logic                glitch_clr,
  output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

  localparam int CW =
    (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LO,
    WAIT_HI,
    STABLE_HI,
    WAIT_LO
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q, out_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          busy_q, busy_d;

  state_t rst_state;
  assign rst_state = RESET_VAL ? STABLE_HI : STABLE_LO;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      STABLE_LO: begin
        if (in) begin
          state_d = WAIT_HI;
          cnt_d   = CW'(1);
        end
      end
      WAIT_HI: begin
        if (!in) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          out_d   = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STABLE_HI: begin
        if (!in) begin
          state_d = WAIT_LO;
          cnt_d   = CW'(1);
        end
      end
      WAIT_LO: begin
        if (in) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          out_d   = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = rst_state;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == WAIT_HI) ||
             (state_d == WAIT_LO);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= rst_state;
      cnt_q   <= '0;
      out_q   <= RESET_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign out  = out_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = busy_q;

`ifdef DEBOUNCE_GLITCH_CNT_EN
  // A glitch is a candidate abandoned before qualifying.
  logic                glitch_ev;
  logic [GLITCH_W-1:0] gcnt_q, gcnt_d;

  assign glitch_ev =
    ((state_q == WAIT_HI) && !in) ||
    ((state_q == WAIT_LO) &&  in);

  always_comb begin
    gcnt_d = gcnt_q;
    if (glitch_clr)
      gcnt_d = '0;
    else if (glitch_ev && !(&gcnt_q))
      gcnt_d = gcnt_q + GLITCH_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) gcnt_q <= '0;
    else        gcnt_q <= gcnt_d;
  end

  assign glitch_cnt = gcnt_q;
`endif

endmodule
